// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over a req/ready handshake and applies redirects on decode ack.
// Optional FETCH_TIMEOUT_EN adds a fetch watchdog that parks the unit in FAULT until reset.
module fetch_unit #(
  parameter int          ADDR_W   = 10,
  parameter int unsigned RESET_PC = 0,
  parameter int          TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [17:0]       imem_rdata,
  input  logic              imem_ready,
  output logic [17:0]       instr,
  output logic              instr_valid,
  input  logic              instr_ack,
  input  logic              pc_write,
  input  logic              branch,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        branch_cnt,
  output logic              fetch_fault
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, FAULT} state_t;

  state_t state, state_nxt;

  // Offset is a signed 10-bit field; the sum wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] calc_target(input logic [ADDR_W-1:0] base,
                                                    input logic signed [9:0] off);
    logic signed [ADDR_W+9:0] ext;
    logic        [ADDR_W+9:0] sum;
    ext = (ADDR_W+10)'(off);
    sum = ext + (ADDR_W+10)'(base) + (ADDR_W+10)'(1);
    return sum[ADDR_W-1:0];
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] tmo_cnt;

  // Counts consecutive unanswered FETCH cycles; zero whenever outside FETCH.
  always_ff @(posedge clk) begin
    if (!reset || state != FETCH) begin
      tmo_cnt <= '0;
    end else if (!imem_ready) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: begin
        if (imem_ready) begin
          state_nxt = EXEC;
`ifdef FETCH_TIMEOUT_EN
        end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
          state_nxt = FAULT;
`endif
        end
      end
      EXEC:  if (instr_ack) state_nxt = FETCH;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc         <= ADDR_W'(RESET_PC);
      instr      <= '0;
      branch_cnt <= '0;
    end else begin
      if (state == FETCH && imem_ready) begin
        instr <= imem_rdata;
      end
      if (state == EXEC && instr_ack) begin
        pc <= pc_write ? calc_target(pc, instr[9:0]) : pc + ADDR_W'(1);
        if (pc_write && branch) begin
          branch_cnt <= sat_inc(branch_cnt);
        end
      end
    end
  end

  assign imem_req    = (state == FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == EXEC);
`ifdef FETCH_TIMEOUT_EN
  assign fetch_fault = (state == FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus a randomized run,
// all checked every cycle against a transaction-level model of the fetch/execute handshake.
module tb_fetch_unit;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 16;
  localparam int DEPTH   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [17:0]       imem_rdata;
  logic              imem_ready;
  logic [17:0]       instr;
  logic              instr_valid;
  logic              instr_ack;
  logic              pc_write;
  logic              branch;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        branch_cnt;
  logic              fetch_fault;

  logic [17:0] mem [DEPTH];

  int errors = 0;
  int checks = 0;

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(0), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .instr(instr), .instr_valid(instr_valid), .instr_ack(instr_ack),
    .pc_write(pc_write), .branch(branch),
    .pc(pc), .branch_cnt(branch_cnt), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-transaction view of where the fetch unit must be.
  bit          m_init  = 0;
  bit          m_fresh;    // first cycle after reset, no request yet
  bit          m_valid;    // an instruction is held for decode
  bit          m_fault;
  int          m_pc;
  int          m_cnt;
  int          m_wait;
  logic [17:0] m_instr;

  function automatic int next_pc(input int p, input logic [17:0] w, input logic redirect);
    int off;
    if (!redirect) return (p + 1) % DEPTH;
    off = int'(w[9:0]);
    if (off >= 512) off -= 1024;
    return (p + 1 + off + 2 * DEPTH) % DEPTH;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_init = 1; m_fresh = 1; m_valid = 0; m_fault = 0;
      m_pc = 0; m_cnt = 0; m_wait = 0; m_instr = '0;
    end else if (m_init) begin
      if (m_fresh) begin
        m_fresh = 0;
      end else if (m_fault) begin
        m_fault = 1;
      end else if (!m_valid) begin
        if (imem_ready) begin
          m_instr = mem[m_pc];
          m_valid = 1;
          m_wait  = 0;
        end else begin
          m_wait++;
`ifdef FETCH_TIMEOUT_EN
          if (m_wait == TIMEOUT) m_fault = 1;
`endif
        end
      end else if (instr_ack) begin
        m_pc = next_pc(m_pc, m_instr, pc_write);
        if (pc_write && branch && m_cnt < 255) m_cnt++;
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("req", 32'(imem_req), 32'(!m_fresh && !m_valid && !m_fault));
      if (imem_req) chk("addr", 32'(imem_addr), 32'(m_pc));
      chk("valid", 32'(instr_valid), 32'(m_valid));
      if (m_valid) chk("instr", 32'(instr), 32'(m_instr));
      chk("pc", 32'(pc), 32'(m_pc));
      chk("bcnt", 32'(branch_cnt), 32'(m_cnt));
      chk("fault", 32'(fetch_fault), 32'(m_fault));
    end
  end

  task automatic cyc(input logic r, input logic a, input logic p, input logic b);
    imem_ready = r; instr_ack = a; pc_write = p; branch = b;
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    imem_ready = 0; instr_ack = 0; pc_write = 0; branch = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 18'($urandom);
    mem[0][9:0]    = 10'h3FB;  // 0+1-5    -> 1020
    mem[5][9:0]    = 10'h3FD;  // 5+1-3    -> 3
    mem[10][9:0]   = 10'h3F4;  // 10+1-12  -> 1023
    mem[1020][9:0] = 10'h005;  // 1020+1+5 -> 2 (wrap)

    // Reset held three cycles
    repeat (3) cyc(0, 0, 0, 0);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_bcnt", 32'(branch_cnt), 0);
    chk("rst_fault", 32'(fetch_fault), 0);
    reset = 1'b1;
    chk("idle_req", 32'(imem_req), 0);
    cyc(0, 0, 0, 0);
    chk("first_req", 32'(imem_req), 1);
    chk("first_addr", 32'(imem_addr), 0);

    // Sequential fetch, branch without pc_write must not count
    for (int k = 0; k < 4; k++) begin
      chk("seq_addr", 32'(imem_addr), 32'(k));
      cyc(1, 1, 0, 1);
      chk("seq_valid", 32'(instr_valid), 1);
      chk("seq_instr", 32'(instr), 32'(mem[k]));
      cyc(1, 1, 0, 1);
    end
    chk("seq_bcnt", 32'(branch_cnt), 0);

    // Redirects from pc=5: backward -3, then forward +4
    cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0); cyc(0, 1, 1, 1);
    chk("redir_back", 32'(imem_addr), 3);
    chk("redir_bcnt1", 32'(branch_cnt), 1);
    mem[5][9:0] = 10'h004;
    repeat (4) cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0); cyc(0, 1, 1, 1);
    chk("redir_fwd", 32'(imem_addr), 10);
    chk("redir_bcnt2", 32'(branch_cnt), 2);

    // Memory wait states, then decode stall
    repeat (4) begin
      cyc(0, 0, 0, 0);
      chk("wait_req", 32'(imem_req), 1);
      chk("wait_addr", 32'(imem_addr), 10);
      chk("wait_valid", 32'(instr_valid), 0);
    end
    cyc(1, 0, 0, 0);
    repeat (5) begin
      cyc(0, 0, 1, 1);
      chk("stall_valid", 32'(instr_valid), 1);
      chk("stall_instr", 32'(instr), 32'(mem[10]));
      chk("stall_pc", 32'(pc), 10);
    end
    cyc(0, 1, 1, 0);
    chk("to_top", 32'(imem_addr), 1023);
    chk("nobranch_bcnt", 32'(branch_cnt), 2);

    // Address wrap: sequential and redirected
    cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
    chk("wrap_seq", 32'(imem_addr), 0);
    cyc(1, 0, 0, 0); cyc(0, 1, 1, 0);
    chk("to_1020", 32'(imem_addr), 1020);
    cyc(1, 0, 0, 0); cyc(0, 1, 1, 1);
    chk("wrap_redir", 32'(imem_addr), 2);
    chk("wrap_bcnt", 32'(branch_cnt), 3);

    // Memory never answers
    repeat (TIMEOUT - 1) cyc(0, 0, 0, 0);
    chk("tmo_pre_fault", 32'(fetch_fault), 0);
    chk("tmo_pre_req", 32'(imem_req), 1);
    cyc(0, 0, 0, 0);
`ifdef FETCH_TIMEOUT_EN
    chk("tmo_fault", 32'(fetch_fault), 1);
    chk("tmo_req", 32'(imem_req), 0);
    chk("tmo_valid", 32'(instr_valid), 0);
    chk("tmo_pc", 32'(pc), 2);
    repeat (3) cyc(1, 1, 1, 1);
    chk("tmo_stuck", 32'(fetch_fault), 1);
    reset = 1'b0;
    cyc(0, 0, 0, 0);
    reset = 1'b1;
    chk("tmo_cleared", 32'(fetch_fault), 0);
`else
    repeat (8) cyc(0, 0, 0, 0);
    chk("tmo_nofault", 32'(fetch_fault), 0);
    chk("tmo_req_held", 32'(imem_req), 1);
    chk("tmo_addr_held", 32'(imem_addr), 2);
`endif

    // Randomized traffic with occasional resets
    reset = 1'b0;
    cyc(0, 0, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = 18'($urandom);
    repeat (2000) begin
      reset = ($urandom_range(99) != 0);
      cyc(($urandom_range(9) < 7), ($urandom_range(9) < 6),
          1'($urandom), 1'($urandom));
    end

    // Branch counter saturation
    reset = 1'b0;
    cyc(0, 0, 0, 0);
    reset = 1'b1;
    repeat (600) cyc(1, 1, 1, 1);
    chk("bcnt_sat", 32'(branch_cnt), 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
